// File: rtl/ahb_dram_pkg.sv
// ahb_dram_pkg: shared definitions for the AHB-Lite DRAM controller.
//   - state_e      : controller FSM states
//   - Htrans*/Hresp*/Hsize* : AHB encodings used by the controller
//   - lane_mask()  : active-high byte-lane mask for a transfer (4 lanes per word)
//   - is_illegal() : capture-time legality check (size, alignment, master permission)
package ahb_dram_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAct,
        StRcd,
        StRcas,
        StCl,
        StWcas,
        StWr,
        StPre,
        StRp,
        StResp,
        StErr1,
        StErr2
    } state_e;

    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic [1:0] HrespOkay  = 2'b00;
    localparam logic [1:0] HrespError = 2'b01;

    localparam logic [2:0] HsizeByte = 3'd0;
    localparam logic [2:0] HsizeHalf = 3'd1;
    localparam logic [2:0] HsizeWord = 3'd2;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            HsizeByte: m = 4'b0001 << lo;
            HsizeHalf: m = lo[1] ? 4'b1100 : 4'b0011;
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic is_illegal(input logic [2:0]  size,
                                        input logic [1:0]  lo,
                                        input logic [3:0]  master,
                                        input logic [15:0] mmask);
        logic bad;
        bad = (size > HsizeWord) ||
              ((size == HsizeHalf) && lo[0]) ||
              ((size == HsizeWord) && (lo != 2'b00)) ||
              !mmask[master];
        return bad;
    endfunction

endpackage

// File: rtl/dram_timer.sv
// dram_timer: loadable down-counter used for DRAM timing waits.
//   clk        in  clock
//   rst        in  asynchronous reset, active-high (clears count)
//   load_i     in  load load_val_i this cycle
//   load_val_i in  value to load (T-1 for a T-cycle wait)
//   done_o     out count has reached zero
module dram_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/ahb_dram_ctrl.sv
// ahb_dram_ctrl: AHB-Lite slave controller for an asynchronous-command DRAM.
// Single reads and byte/half/word writes; fixed counted latencies (no data-valid on DRAM_Q).
// Optional feature macro: DRAM_OPEN_ROW_EN (keep the row open after CL/WR, skip ACT on hits).
// Ports:
//   clk, rst                      clock, async active-high reset
//   HSEL/HTRANS/HADDR/HWRITE      AHB address phase
//   HSIZE/HWDATA/HMASTER          AHB size, write data (first data-phase cycle), master id
//   HRDATA/HREADY/HRESP           AHB response
//   DRAM_CSn/DRAM_WEn/RASn/CASn   DRAM command strobes (low active, WEn per byte)
//   address/DI/DRAM_Q             DRAM row/column address, write data, read data
module ahb_dram_ctrl
    import ahb_dram_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ROW_W       = 11,
    parameter int unsigned COL_W       = 11,
    parameter int unsigned T_RCD       = 2,
    parameter int unsigned T_CAS       = 3,
    parameter int unsigned T_WR        = 1,
    parameter int unsigned T_RP        = 2,
    parameter logic [15:0] MASTER_MASK = 16'h0002
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                HSEL,
    input  logic [1:0]          HTRANS,
    input  logic [31:0]         HADDR,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [DATA_W-1:0]   HWDATA,
    input  logic [3:0]          HMASTER,
    input  logic [DATA_W-1:0]   DRAM_Q,
    output logic [DATA_W-1:0]   HRDATA,
    output logic                HREADY,
    output logic [1:0]          HRESP,
    output logic                DRAM_CSn,
    output logic [DATA_W/8-1:0] DRAM_WEn,
    output logic                RASn,
    output logic                CASn,
    output logic [ROW_W-1:0]    address,
    output logic [DATA_W-1:0]   DI
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned TMax1 = (T_RCD > T_CAS) ? T_RCD : T_CAS;
    localparam int unsigned TMax2 = (T_WR > T_RP) ? T_WR : T_RP;
    localparam int unsigned TMax  = (TMax1 > TMax2) ? TMax1 : TMax2;
    localparam int unsigned TW    = $clog2(TMax) + 1;

    state_e              state_q, state_d, start_st;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic [3:0]          lanes_q;
    logic                write_q;
    logic                dphase_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [NB-1:0]       wen_lanes;
    logic                capture, illegal;
    logic [ROW_W-1:0]    cap_row;
    logic                tmr_load, tmr_done;
    logic [TW-1:0]       tmr_val;
    logic                unused_haddr;

    assign unused_haddr = ^HADDR;
    assign cap_row      = HADDR[ROW_W+COL_W+1:COL_W+2];
    assign illegal      = is_illegal(HSIZE, HADDR[1:0], HMASTER, MASTER_MASK);
    // HREADY is high only in IDLE/RESP/ERR2; captures are accepted only in IDLE/RESP.
    assign capture      = HSEL && ((HTRANS == HtransNonseq) || (HTRANS == HtransSeq)) &&
                          ((state_q == StIdle) || (state_q == StResp));

`ifdef DRAM_OPEN_ROW_EN
    logic [ROW_W-1:0] open_row_q;
    logic             open_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_row_q   <= '0;
            open_valid_q <= 1'b0;
        end else if (state_q == StAct) begin
            open_row_q   <= row_q;
            open_valid_q <= 1'b1;
        end else if (state_q == StPre) begin
            open_valid_q <= 1'b0;
        end
    end

    always_comb begin
        start_st = StAct;
        if (illegal) begin
            start_st = StErr1;
        end else if (open_valid_q && (open_row_q == cap_row)) begin
            start_st = HWRITE ? StWcas : StRcas;
        end else if (open_valid_q) begin
            start_st = StPre;
        end
    end
`else
    always_comb begin
        start_st = illegal ? StErr1 : StAct;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StResp: state_d = capture ? start_st : StIdle;
            StAct:          state_d = StRcd;
            StRcd:          if (tmr_done) state_d = write_q ? StWcas : StRcas;
            StRcas:         state_d = StCl;
            StWcas:         state_d = StWr;
`ifdef DRAM_OPEN_ROW_EN
            StCl:           if (tmr_done) state_d = StResp;
            StWr:           if (tmr_done) state_d = StResp;
            // RP is only reached on a row miss, so a new ACT always follows.
            StRp:           if (tmr_done) state_d = StAct;
`else
            StCl:           if (tmr_done) state_d = StPre;
            StWr:           if (tmr_done) state_d = StPre;
            StRp:           if (tmr_done) state_d = StResp;
`endif
            StPre:          state_d = StRp;
            StErr1:         state_d = StErr2;
            StErr2:         state_d = StIdle;
            default:        state_d = StIdle;
        endcase
    end

    // Timer is reloaded on every state change with the entered state's wait minus one.
    always_comb begin
        tmr_val = '0;
        case (state_d)
            StRcd:   tmr_val = TW'(T_RCD - 1);
            StCl:    tmr_val = TW'(T_CAS - 1);
            StWr:    tmr_val = TW'(T_WR - 1);
            StRp:    tmr_val = TW'(T_RP - 1);
            default: tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_d != state_q);

    dram_timer #(
        .Width (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            row_q    <= '0;
            col_q    <= '0;
            lanes_q  <= '0;
            write_q  <= 1'b0;
            dphase_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            dphase_q <= capture;
            if (capture) begin
                row_q   <= cap_row;
                col_q   <= HADDR[COL_W+1:2];
                lanes_q <= lane_mask(HSIZE, HADDR[1:0]);
                write_q <= HWRITE;
            end
            if (dphase_q) begin
                wdata_q <= HWDATA;
            end
            if ((state_q == StCl) && tmr_done) begin
                rdata_q <= DRAM_Q;
            end
        end
    end

    // Lane mask repeats every four byte lanes for data widths beyond one word.
    always_comb begin
        wen_lanes = '1;
        for (int i = 0; i < NB; i++) begin
            wen_lanes[i] = ~lanes_q[2'(i % 4)];
        end
    end

    // Outputs decode directly from state so reset takes effect immediately.
    always_comb begin
        HREADY   = 1'b0;
        HRESP    = HrespOkay;
        HRDATA   = '0;
        DRAM_CSn = 1'b0;
        DRAM_WEn = '1;
        RASn     = 1'b1;
        CASn     = 1'b1;
        address  = '0;
        DI       = '0;
        case (state_q)
            StIdle: begin
                HREADY   = 1'b1;
                DRAM_CSn = 1'b1;
            end
            StResp: begin
                HREADY   = 1'b1;
                DRAM_CSn = 1'b1;
                if (!write_q) HRDATA = rdata_q;
            end
            StErr1: begin
                DRAM_CSn = 1'b1;
                HRESP    = HrespError;
            end
            StErr2: begin
                HREADY   = 1'b1;
                DRAM_CSn = 1'b1;
                HRESP    = HrespError;
            end
            StAct: begin
                RASn    = 1'b0;
                address = row_q;
            end
            StRcas: begin
                CASn                = 1'b0;
                address[COL_W-1:0]  = col_q;
            end
            StWcas: begin
                CASn                = 1'b0;
                address[COL_W-1:0]  = col_q;
                DRAM_WEn            = wen_lanes;
                DI                  = wdata_q;
            end
            StPre: begin
                RASn     = 1'b0;
                DRAM_WEn = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_dram_ctrl.sv
module tb_ahb_dram_ctrl;

    localparam int TRCD = 2;
    localparam int TCAS = 3;
    localparam int TWR  = 1;
    localparam int TRP  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [3:0]  HMASTER;
    logic [31:0] DRAM_Q;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic        DRAM_CSn;
    logic [3:0]  DRAM_WEn;
    logic        RASn;
    logic        CASn;
    logic [10:0] address;
    logic [31:0] DI;

    always #5 clk = ~clk;

    ahb_dram_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .HSEL     (HSEL),
        .HTRANS   (HTRANS),
        .HADDR    (HADDR),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HMASTER  (HMASTER),
        .DRAM_Q   (DRAM_Q),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP),
        .DRAM_CSn (DRAM_CSn),
        .DRAM_WEn (DRAM_WEn),
        .RASn     (RASn),
        .CASn     (CASn),
        .address  (address),
        .DI       (DI)
    );

    typedef struct {
        int          waits;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          acts;
        int          pres;
        int          cas;
        logic [10:0] row;
        logic [10:0] col;
        logic [3:0]  wen;
        logic [31:0] di;
        logic        cs_low;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_valid = 1'b0;
    logic [10:0] m_row = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hrdata"}, HRDATA, 32'h0);
        check({tag, "_hready"}, {31'b0, HREADY}, 32'h1);
        check({tag, "_hresp"}, {30'b0, HRESP}, 32'h0);
        check({tag, "_csn"}, {31'b0, DRAM_CSn}, 32'h1);
        check({tag, "_wen"}, {28'b0, DRAM_WEn}, 32'hF);
        check({tag, "_rasn"}, {31'b0, RASn}, 32'h1);
        check({tag, "_casn"}, {31'b0, CASn}, 32'h1);
        check({tag, "_addr"}, {21'b0, address}, 32'h0);
        check({tag, "_di"}, DI, 32'h0);
    endtask

    // Independent model of the expected response and DRAM command sequence.
    task automatic push_exp(input logic [31:0] addr, input bit write, input logic [2:0] size,
                            input logic [3:0] master, input logic [31:0] wdata,
                            input logic [31:0] q);
        exp_t e;
        bit   legal;
        int   dwait;
        legal = (size == 3'd0) || (size == 3'd1 && addr[0] == 1'b0) ||
                (size == 3'd2 && addr[1:0] == 2'b00);
        legal = legal && (master == 4'd1);
        e.row = addr[23:13];
        e.col = addr[12:2];
        if (!legal) begin
            e.waits = 1; e.resp = 2'b01; e.rdata = 32'h0;
            e.acts = 0; e.pres = 0; e.cas = 0; e.cs_low = 1'b0;
            e.wen = 4'hF; e.di = 32'h0;
        end else begin
            e.resp   = 2'b00;
            e.rdata  = write ? 32'h0 : q;
            e.cas    = 1;
            e.cs_low = 1'b1;
            e.di     = write ? wdata : 32'h0;
            if (!write)              e.wen = 4'hF;
            else if (size == 3'd0)   e.wen = ~(4'b0001 << addr[1:0]);
            else if (size == 3'd1)   e.wen = ~(4'b0011 << {addr[1], 1'b0});
            else                     e.wen = 4'h0;
            dwait = write ? TWR : TCAS;
`ifdef DRAM_OPEN_ROW_EN
            if (m_valid && m_row == e.row) begin
                e.acts = 0; e.pres = 0; e.waits = 1 + dwait;
            end else if (m_valid) begin
                e.acts = 1; e.pres = 1; e.waits = 1 + TRP + 1 + TRCD + 1 + dwait;
            end else begin
                e.acts = 1; e.pres = 0; e.waits = 1 + TRCD + 1 + dwait;
            end
            m_valid = 1'b1;
            m_row   = e.row;
`else
            e.acts  = 1;
            e.pres  = 1;
            e.waits = 1 + TRCD + 1 + dwait + 1 + TRP;
`endif
        end
        sb.push_back(e);
    endtask

    task automatic do_xfer(input string tag, input logic [31:0] addr, input bit write,
                           input logic [2:0] size, input logic [3:0] master,
                           input logic [31:0] wdata, input logic [31:0] q);
        exp_t        e;
        int          waits = 0, acts = 0, pres = 0, cas = 0;
        bit          done = 1'b0;
        logic        cs_low = 1'b0;
        logic [1:0]  first_resp = 2'b11, fin_resp = 2'b11;
        logic [31:0] fin_rdata = '0, cas_di = '0;
        logic [10:0] act_row = '0, cas_col = '0;
        logic [3:0]  cas_wen = '1;
        push_exp(addr, write, size, master, wdata, q);
        @(negedge clk);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = write;
        HSIZE = size; HMASTER = master; DRAM_Q = q;
        @(posedge clk);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (HREADY) begin
                done      = 1'b1;
                fin_resp  = HRESP;
                fin_rdata = HRDATA;
            end else begin
                waits++;
                if (waits == 1) first_resp = HRESP;
                if (!DRAM_CSn) cs_low = 1'b1;
                if (!RASn && DRAM_WEn == 4'hF) begin acts++; act_row = address; end
                if (!RASn && DRAM_WEn == 4'h0) pres++;
                if (!CASn) begin
                    cas++; cas_col = address; cas_wen = DRAM_WEn; cas_di = DI;
                end
            end
        end
        e = sb.pop_front();
        check({tag, "_done"}, {31'b0, done}, 32'h1);
        check({tag, "_waits"}, waits, e.waits);
        check({tag, "_wresp"}, {30'b0, first_resp}, {30'b0, e.resp});
        check({tag, "_resp"}, {30'b0, fin_resp}, {30'b0, e.resp});
        check({tag, "_rdata"}, fin_rdata, e.rdata);
        check({tag, "_acts"}, acts, e.acts);
        check({tag, "_pres"}, pres, e.pres);
        check({tag, "_cas"}, cas, e.cas);
        check({tag, "_cslow"}, {31'b0, cs_low}, {31'b0, e.cs_low});
        if (e.acts > 0) check({tag, "_row"}, {21'b0, act_row}, {21'b0, e.row});
        if (e.cas > 0) begin
            check({tag, "_col"}, {21'b0, cas_col}, {21'b0, e.col});
            check({tag, "_wen"}, {28'b0, cas_wen}, {28'b0, e.wen});
            check({tag, "_di"}, cas_di, e.di);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_cas;
        rst = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        HSIZE = 3'd2; HWDATA = '0; HMASTER = 4'd1; DRAM_Q = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // IDLE transfer while selected: zero-wait OKAY, no DRAM activity
        @(negedge clk);
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h0000_0040;
        @(negedge clk);
        check("idle_hready", {31'b0, HREADY}, 32'h1);
        check("idle_hresp", {30'b0, HRESP}, 32'h0);
        check("idle_csn", {31'b0, DRAM_CSn}, 32'h1);
        HSEL = 1'b0;

        do_xfer("rd_word", 32'h0000_1804, 1'b0, 3'd2, 4'd1, 32'h0, 32'hDEAD_BEEF);
        do_xfer("wr_byte", 32'h0000_0002, 1'b1, 3'd0, 4'd1, 32'h00AA_0000, 32'h0);
        do_xfer("wr_half", 32'h0000_0000, 1'b1, 3'd1, 4'd1, 32'h1234_5678, 32'h0);
        do_xfer("wr_word", 32'h0000_0010, 1'b1, 3'd2, 4'd1, 32'hA5A5_5A5A, 32'h0);
        do_xfer("err_misal", 32'h0000_0001, 1'b0, 3'd1, 4'd1, 32'h0, 32'h1111_1111);
        do_xfer("err_master", 32'h0000_0004, 1'b0, 3'd2, 4'd0, 32'h0, 32'h2222_2222);
        do_xfer("err_size", 32'h0000_0008, 1'b0, 3'd3, 4'd1, 32'h0, 32'h3333_3333);
        do_xfer("rd_same_row", 32'h0000_1808, 1'b0, 3'd2, 4'd1, 32'h0, 32'hCAFE_F00D);
        do_xfer("rd_new_row", 32'h0004_2000, 1'b0, 3'd2, 4'd1, 32'h0, 32'h0BAD_F00D);

        // Reset during CL: abandon the access, outputs return to reset values immediately
        @(negedge clk);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0004_2004; HWRITE = 1'b0;
        HSIZE = 3'd2; HMASTER = 4'd1; DRAM_Q = 32'h7777_7777;
        @(posedge clk);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        seen_cas = 1'b0;
        for (int i = 0; i < 32 && !seen_cas; i++) begin
            @(negedge clk);
            if (!CASn) seen_cas = 1'b1;
        end
        check("rstcl_cas_seen", {31'b0, seen_cas}, 32'h1);
        @(negedge clk);
        check("rstcl_in_cl", {31'b0, HREADY}, 32'h0);
        rst = 1'b1;
        #1;
        check_reset_outputs("rstcl");
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;

        do_xfer("rd_after_rst", 32'h0004_2004, 1'b0, 3'd2, 4'd1, 32'h0, 32'h5555_AAAA);
        do_xfer("wr_after_rst", 32'h0004_2006, 1'b1, 3'd1, 4'd1, 32'hBEEF_0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
